// File: rtl/hack_decoder_pkg.sv
// Shared mode constants and one-hot helper for the
// sequenced Hack decoder family.
package hack_decoder_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_LATCH   = 2'b01;
  localparam logic [1:0] MODE_SCAN    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  // Widest select supported; callers size-cast the result.
  localparam int SEL_MAX = 8;
  localparam int OUT_MAX = 2 ** SEL_MAX;

  function automatic logic [OUT_MAX-1:0] onehot(
    input logic [SEL_MAX-1:0] s
  );
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/hack_decoder_seq_scan.sv
// hack_scan_counter: prescaler plus modulo-OUT_W scan index.
// Ports: clk, rst_n, i_en (advance), i_clr (restart at 0),
// o_idx (current index), o_wrap (this cycle steps last->0).
module hack_scan_counter #(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_wrap
);

  logic [15:0]      r_presc;
  logic [SEL_W-1:0] r_idx;
  logic             w_step;

  assign w_step = i_en && (r_presc == 16'(SCAN_DIV - 1));
  assign o_wrap = w_step && (&r_idx);
  assign o_idx  = r_idx;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      if (w_step) begin
        r_presc <= '0;
        // OUT_W is a power of two, so natural rollover is modulo OUT_W.
        r_idx   <= r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

endmodule

// File: rtl/hack_decoder_seq.sv
// hack_decoder_seq: registered SEL_W -> 2**SEL_W one-hot decoder
// with DIRECT, LATCH, SCAN and ONESHOT modes (SEL_W <= 8).
// Ports: clk, rst_n (sync, low), en, mode[1:0], sel, load in;
// out (one-hot or zero), idx (last active index), wrap out.
module hack_decoder_seq
  import hack_decoder_pkg::*;
#(
  parameter int SCAN_DIV = 1,
  parameter int SEL_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  logic [OUT_W-1:0] r_out;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_lat;
  logic             r_wrap;

  logic [SEL_W-1:0] w_sidx;
  logic             w_swrap;
  logic             w_is_scan;
  logic [SEL_W-1:0] w_lsel;
  logic [SEL_W-1:0] w_sel;
  logic             w_act;
  logic [OUT_W-1:0] w_oh;

  assign w_is_scan = (mode == MODE_SCAN);

  // Counter only runs in SCAN; any other mode holds it at 0
  // so each SCAN entry starts from index 0.
  hack_scan_counter #(
    .SEL_W    (SEL_W),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en && w_is_scan),
    .i_clr  (!w_is_scan),
    .o_idx  (w_sidx),
    .o_wrap (w_swrap)
  );

  // A load in LATCH decodes the new value at the same edge.
  assign w_lsel = load ? sel : r_lat;

  always_comb begin
    w_sel = sel;
    w_act = 1'b0;
    unique case (mode)
      MODE_DIRECT: begin
        w_act = en;
      end
      MODE_LATCH: begin
        w_sel = w_lsel;
        w_act = en;
      end
      MODE_SCAN: begin
        w_sel = w_sidx;
        w_act = en;
      end
      MODE_ONESHOT: begin
        w_act = en && load;
      end
    endcase
  end

  assign w_oh = OUT_W'(onehot(SEL_MAX'(w_sel)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_idx  <= '0;
      r_lat  <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (w_act) begin
        r_out <= w_oh;
        r_idx <= w_sel;
      end else begin
        r_out <= '0;
      end
      // Latch captures even with en=0.
      if (mode == MODE_LATCH && load) r_lat <= sel;
      r_wrap <= w_is_scan && w_swrap;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_hack_decoder_seq.sv
// Bench for hack_decoder_seq: three instances (2b/div3,
// 3b/div2, 2b/div1) driven in lockstep against a model.
module tb_hack_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] sel;
  logic       load;

  logic [3:0] out_a, out_c;
  logic [7:0] out_b;
  logic [1:0] idx_a, idx_c;
  logic [2:0] idx_b;
  logic       wrap_a, wrap_b, wrap_c;

  always #5 clk = ~clk;

  hack_decoder_seq #(.SCAN_DIV(3), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel[1:0]), .load(load),
    .out(out_a), .idx(idx_a), .wrap(wrap_a)
  );

  hack_decoder_seq #(.SCAN_DIV(2), .SEL_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel), .load(load),
    .out(out_b), .idx(idx_b), .wrap(wrap_b)
  );

  hack_decoder_seq #(.SCAN_DIV(1), .SEL_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel(sel[1:0]), .load(load),
    .out(out_c), .idx(idx_c), .wrap(wrap_c)
  );

  logic [7:0] ao [3];
  logic [2:0] ai [3];
  logic       aw [3];
  assign ao[0] = {4'b0, out_a};
  assign ao[1] = out_b;
  assign ao[2] = {4'b0, out_c};
  assign ai[0] = {1'b0, idx_a};
  assign ai[1] = idx_b;
  assign ai[2] = {1'b0, idx_c};
  assign aw[0] = wrap_a;
  assign aw[1] = wrap_b;
  assign aw[2] = wrap_c;

  int mw [3] = '{2, 3, 2};
  int md [3] = '{3, 2, 1};
  int mlat [3];
  int mt [3];
  int meo [3];
  int mei [3];
  int mew [3];

  int pass_cnt = 0;
  int total = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // Model: scan position derived from the count of enabled
  // SCAN cycles since entry, not from a counter replica.
  task automatic model_step();
    int n, s, i;
    for (int k = 0; k < 3; k++) begin
      n = 1 << mw[k];
      s = int'(sel) % n;
      if (!rst_n) begin
        meo[k] = 0; mei[k] = 0; mew[k] = 0;
        mlat[k] = 0; mt[k] = 0;
      end else begin
        mew[k] = 0;
        case (mode)
          2'd0: if (en) begin meo[k] = 1 << s; mei[k] = s; end
                else meo[k] = 0;
          2'd1: begin
            if (load) mlat[k] = s;
            if (en) begin meo[k] = 1 << mlat[k]; mei[k] = mlat[k]; end
            else meo[k] = 0;
          end
          2'd2: if (en) begin
            i = (mt[k] / md[k]) % n;
            meo[k] = 1 << i;
            mei[k] = i;
            mew[k] = int'((mt[k] % md[k] == md[k] - 1) && (i == n - 1));
            mt[k]++;
          end else meo[k] = 0;
          default: if (en && load) begin meo[k] = 1 << s; mei[k] = s; end
                   else meo[k] = 0;
        endcase
        if (mode != 2'd2) mt[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out[%0d]", k), int'(ao[k]), meo[k]);
      chk($sformatf("idx[%0d]", k), int'(ai[k]), mei[k]);
      chk($sformatf("wrap[%0d]", k), int'(aw[k]), mew[k]);
      chk($sformatf("onehot[%0d]", k), int'($countones(ao[k]) <= 1), 1);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(logic r, logic e, logic [1:0] m,
                       logic [2:0] s, logic l);
    rst_n = r; en = e; mode = m; sel = s; load = l;
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [1:0] m;
    logic [2:0] s;
    logic       l;
    logic [3:0] exp_a;
  } vec_t;

  vec_t vecs [17];
  int   wa, wb, guard;

  initial begin
    vecs[0]  = '{1, 1, 0, 0, 0, 4'b0001};
    vecs[1]  = '{1, 1, 0, 1, 0, 4'b0010};
    vecs[2]  = '{1, 1, 0, 2, 0, 4'b0100};
    vecs[3]  = '{1, 1, 0, 3, 0, 4'b1000};
    vecs[4]  = '{1, 0, 0, 3, 0, 4'b0000};
    vecs[5]  = '{1, 1, 1, 2, 1, 4'b0100};
    vecs[6]  = '{1, 1, 1, 0, 0, 4'b0100};
    vecs[7]  = '{1, 0, 1, 0, 0, 4'b0000};
    vecs[8]  = '{1, 1, 1, 0, 0, 4'b0100};
    vecs[9]  = '{1, 0, 1, 1, 1, 4'b0000};
    vecs[10] = '{1, 1, 1, 3, 0, 4'b0010};
    vecs[11] = '{1, 1, 3, 3, 1, 4'b1000};
    vecs[12] = '{1, 1, 3, 1, 1, 4'b0010};
    vecs[13] = '{1, 1, 3, 1, 0, 4'b0000};
    vecs[14] = '{1, 0, 3, 2, 1, 4'b0000};
    vecs[15] = '{1, 1, 3, 2, 0, 4'b0000};
    vecs[16] = '{0, 1, 0, 3, 0, 4'b0000};

    drive(0, 0, 0, 0, 0);
    tick();
    chk("reset_out", int'(out_a), 0);

    for (int v = 0; v < 17; v++) begin
      drive(vecs[v].r, vecs[v].e, vecs[v].m, vecs[v].s, vecs[v].l);
      tick();
      chk($sformatf("vec%0d_out", v), int'(out_a), int'(vecs[v].exp_a));
    end

    // SCAN from entry: timing, wrap counts, DIV=1 sequence.
    drive(1, 1, 2, 0, 0);
    wa = 0; wb = 0;
    for (int j = 0; j < 24; j++) begin
      tick();
      chk("scan_a", int'(out_a), 1 << ((j / 3) % 4));
      if (j < 5) chk("divone_seq", int'(out_c), 1 << (j % 4));
      wa += int'(wrap_a);
      wb += int'(wrap_b);
    end
    chk("wrap_cnt_a", wa, 2);
    chk("wrap_cnt_b", wb, 1);

    // Freeze mid-step, resume with remaining count.
    drive(0, 1, 2, 0, 0);
    tick();
    drive(1, 1, 2, 0, 0);
    repeat (4) tick();
    en = 0;
    repeat (3) tick();
    chk("frozen_out", int'(out_a), 0);
    chk("frozen_idx", int'(idx_a), 1);
    en = 1;
    tick(); chk("resume0", int'(out_a), 4'b0010);
    tick(); chk("resume1", int'(out_a), 4'b0010);
    tick(); chk("resume2", int'(out_a), 4'b0100);

    // Reset mid-scan at index 2.
    guard = 0;
    while (out_a != 4'b0100 && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_idx2", int'(out_a), 4'b0100);
    rst_n = 0;
    tick();
    chk("rst_scan_out", int'(out_a), 0);
    chk("rst_scan_idx", int'(idx_a), 0);
    chk("rst_scan_wrap", int'(wrap_a), 0);
    rst_n = 1;
    tick();
    chk("restart_out", int'(out_a), 4'b0001);

    // Randomized run with sticky modes so SCAN gets exercised.
    for (int j = 0; j < 400; j++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      en    = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) mode = 2'($urandom_range(0, 3));
      sel   = 3'($urandom_range(0, 7));
      load  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
